sw_debounce: RTL and testbench
==============================

Name: sw_debounce

Overview:
- Front-end conditioning stage for the board slide switches.
- Sits upstream of the computer top: board pins go into sw_raw, and sw_db drives the top's 16-bit `sw` input, which the switch I/O select path returns to the CPU.
- Synchronises each raw switch into the clock domain, then debounces it with a per-bit stability counter.
- Emits a one-cycle change strobe, plus optional sticky per-bit event flags for polling software.

Parameters:
- WIDTH, 16, number of switch channels.
- DEBOUNCE_CYCLES, 1000000, consecutive mismatching clock edges required before a debounced bit flips (10 ms at 100 MHz). Legal range: ≥1.
- CNT_W, 20, per-channel counter width. Must satisfy 2^CNT_W ≥ DEBOUNCE_CYCLES.

Ports:
- clk_in  in  1  board clock (undivided); all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset.
- sw_raw  in  WIDTH  asynchronous raw switch levels from pins.
- evt_clr  in  1  one-cycle pulse; clears sw_evt (optional feature only).
- sw_db  out  WIDTH  debounced, registered switch levels; feeds top-level `sw`.
- sw_chg  out  1  one-cycle strobe; some sw_db bit changed at this edge.
- sw_evt  out  WIDTH  sticky per-bit change flags (optional feature).

Behaviour:
- Reset: sampled on the clk_in rising edge while reset==0. It clears s1, s2, sw_db, all counters, sw_chg and sw_evt to 0. Reset mid-debounce discards partial counts; no flip occurs on the edge after release.
- Synchroniser: two flops per bit. s1 <= sw_raw; s2 <= s1. No logic sits between the two flops.
- Per-bit state machine: 2 implicit states per bit, STABLE (cnt==0) and COUNTING (cnt>0). At each non-reset edge, for bit i:
  - s2[i]==sw_db[i]: cnt[i] <= 0. A glitch shorter than DEBOUNCE_CYCLES edges is fully rejected.
  - s2[i]!=sw_db[i] and cnt[i]==DEBOUNCE_CYCLES-1: sw_db[i] <= s2[i]; cnt[i] <= 0.
  - s2[i]!=sw_db[i] otherwise: cnt[i] <= cnt[i]+1.
- Latency: raw change captured by s1 at edge k → sw_db changes at edge k+1+DEBOUNCE_CYCLES. With DEBOUNCE_CYCLES=1, the flip happens on the first mismatching edge (k+2).
- Counter never wraps; the compare at DEBOUNCE_CYCLES-1 bounds it. Unsigned arithmetic, CNT_W bits.
- Channels are fully independent. Simultaneous flips on several bits in one edge are legal and produce a single sw_chg pulse.
- sw_chg: registered. sw_chg <= OR of the per-bit flip conditions at the same edge, so it is high for exactly the one cycle in which the new sw_db is first visible. Flips on consecutive edges produce consecutive high cycles (no merging logic).
- A raw level that toggles back before completion restarts the count from 0 on the next mismatch.

Optional Feature:
- Macro: SW_DEBOUNCE_EVENT_LATCH_EN.
- Defined:
  - sw_evt[i] <= 1 on any edge where bit i flips.
  - evt_clr==1 clears all sw_evt bits.
  - Same-edge flip and clear: the flip wins for that bit (event not lost); other bits clear.
  - Reset value 0.
- Undefined: sw_evt is driven constant 0, evt_clr is ignored, and no event flops are synthesised.

Test Plan (WIDTH=16, DEBOUNCE_CYCLES=4):
- Hold reset=0 for 3 cycles with sw_raw=16'hFFFF, then release → sw_db=16'h0000 and sw_chg=0 through the release edge; sw_db=16'hFFFF first visible 6 edges after release. sw_chg pulses once, coincident with that.
- sw_raw[3] 0→1 held, captured by s1 at edge k → sw_db=16'h0008 from edge k+5; sw_chg high exactly 1 cycle; no earlier change.
- sw_raw[0] pulsed high for 3 cycles then low → sw_db stays 16'h0000 and sw_chg never asserts.
- sw_raw 16'h0000→16'hA5A5 in one cycle → all eight bits flip on the same edge; single 1-cycle sw_chg.
- sw_raw[7] high for 3 cycles, reset=0 for 1 cycle, then reset=1 with sw_raw[7] still high → sw_db[7] flips 6 edges after release, not earlier.
- With SW_DEBOUNCE_EVENT_LATCH_EN: flip bit 2 → sw_evt=16'h0004. Assert evt_clr on the same edge bit 5 flips → sw_evt=16'h0020. Without the macro, sw_evt stays 16'h0000 throughout.

Source files
------------

// File: rtl/sw_debounce_if.sv
// Switch conditioning bus: raw pin levels and event-clear in; debounced levels,
// change strobe and sticky event flags out.
interface sw_debounce_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic [WIDTH-1:0] sw_raw;
  logic             evt_clr;
  logic [WIDTH-1:0] sw_db;
  logic             sw_chg;
  logic [WIDTH-1:0] sw_evt;

  // Driver side (board pins / software clear), consumer of conditioned levels.
  modport master (
    output sw_raw,
    output evt_clr,
    input  sw_db,
    input  sw_chg,
    input  sw_evt
  );

  // Debouncer side.
  modport slave (
    input  sw_raw,
    input  evt_clr,
    output sw_db,
    output sw_chg,
    output sw_evt
  );
endinterface

// File: rtl/sw_debounce.sv
// Slide-switch front end: two-flop synchroniser per bit, then a per-bit stability
// counter that flips the debounced level after DEBOUNCE_CYCLES consecutive
// mismatching edges. sw_chg pulses for the cycle a new sw_db is first visible.
// Optional sticky per-bit event flags are built when SW_DEBOUNCE_EVENT_LATCH_EN
// is defined; otherwise sw_evt is tied to 0 and evt_clr is ignored.
module sw_debounce #(
  parameter int unsigned WIDTH           = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input logic          clk_in,
  input logic          reset,
  sw_debounce_if.slave sw_bus
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] db_q;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic             chg_q;
  logic [WIDTH-1:0] flip;

  // A bit flips when it still mismatches and the count has reached its last value.
  always_comb begin
    flip = '0;
    for (int i = 0; i < WIDTH; i++) begin
      flip[i] = (s2_q[i] != db_q[i]) && (cnt_q[i] == CntLast);
    end
  end

  // Synchroniser, debounced levels, per-bit counters and change strobe.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      s1_q  <= '0;
      s2_q  <= '0;
      db_q  <= '0;
      chg_q <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q  <= sw_bus.sw_raw;
      s2_q  <= s1_q;
      db_q  <= db_q ^ flip;
      chg_q <= |flip;
      for (int i = 0; i < WIDTH; i++) begin
        // Any agreement (or a completed flip) restarts the stability window.
        if ((s2_q[i] == db_q[i]) || flip[i]) begin
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign sw_bus.sw_db  = db_q;
  assign sw_bus.sw_chg = chg_q;

`ifdef SW_DEBOUNCE_EVENT_LATCH_EN
  logic [WIDTH-1:0] evt_q;

  // Sticky flags: a flip on the same edge as a clear keeps its flag.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      evt_q <= '0;
    end else begin
      evt_q <= (sw_bus.evt_clr ? '0 : evt_q) | flip;
    end
  end

  assign sw_bus.sw_evt = evt_q;
`else
  logic unused_evt_clr;
  assign unused_evt_clr = sw_bus.evt_clr;
  assign sw_bus.sw_evt  = '0;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce (WIDTH=16, DEBOUNCE_CYCLES=4): directed scenarios followed
// by randomized switch activity, all checked against a windowed reference model.
module tb_sw_debounce;

  localparam int unsigned W = 16;
  localparam int unsigned N = 4;
  localparam int HistLen    = 8192;

  logic clk_in = 1'b0;
  logic reset  = 1'b0;

  sw_debounce_if #(.WIDTH(W)) bus ();

  sw_debounce #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(N),
    .CNT_W          (3)
  ) dut (
    .clk_in(clk_in),
    .reset (reset),
    .sw_bus(bus)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: raw samples pass through a 2-deep delay line; bit i flips at
  // edge t when the delayed sample disagreed with the debounced level on each of
  // the last N edges, all of them after the bit's last flip or reset.
  int           t_m = 0;
  logic [W-1:0] dly1_m = '0, dly2_m = '0;
  logic [W-1:0] db_m = '0, evt_m = '0;
  logic         chg_m = 1'b0;
  logic [W-1:0] mism_hist [HistLen];
  int           last_evt [W];

  task automatic model_edge();
    logic [W-1:0] s2v;
    logic [W-1:0] flip;
    bit ok;
    t_m++;
    if (!reset) begin
      dly1_m = '0; dly2_m = '0; db_m = '0; chg_m = 1'b0; evt_m = '0;
      mism_hist[t_m] = '0;
      for (int i = 0; i < W; i++) last_evt[i] = t_m;
      return;
    end
    s2v    = dly2_m;
    dly2_m = dly1_m;
    dly1_m = bus.sw_raw;
    mism_hist[t_m] = s2v ^ db_m;
    flip = '0;
    for (int i = 0; i < W; i++) begin
      ok = 1'b1;
      for (int j = 0; j < int'(N); j++) begin
        if ((t_m - j <= last_evt[i]) || !mism_hist[t_m - j][i]) ok = 1'b0;
      end
      if (ok) begin
        flip[i]     = 1'b1;
        last_evt[i] = t_m;
      end
    end
    db_m  = db_m ^ flip;
    chg_m = |flip;
`ifdef SW_DEBOUNCE_EVENT_LATCH_EN
    evt_m = (bus.evt_clr ? '0 : evt_m) | flip;
`else
    evt_m = '0;
`endif
  endtask

  // One clock edge: update the model with the inputs the DUT sampled, then check.
  task automatic step();
    @(posedge clk_in);
    model_edge();
    #1;
    check("db", 32'(bus.sw_db), 32'(db_m));
    check("chg", 32'(bus.sw_chg), 32'(chg_m));
    check("evt", 32'(bus.sw_evt), 32'(evt_m));
  endtask

  // Run n edges (numbered from 1); report the first edge where sw_db changed,
  // how many sw_chg pulses were seen and the edge of the last one.
  task automatic measure(input int n, output int first, output int nchg, output int chg_at);
    logic [W-1:0] prev;
    first = -1; nchg = 0; chg_at = -1;
    for (int s = 1; s <= n; s++) begin
      prev = bus.sw_db;
      step();
      if (bus.sw_db != prev && first < 0) first = s;
      if (bus.sw_chg) begin
        nchg++;
        chg_at = s;
      end
    end
  endtask

  task automatic settle(input logic [W-1:0] raw);
    bus.sw_raw = raw;
    repeat (12) step();
  endtask

  int first, nchg, chg_at, n0, c0, a0;

  initial begin
    for (int i = 0; i < W; i++) last_evt[i] = 0;
    bus.sw_raw  = 16'hFFFF;
    bus.evt_clr = 1'b0;
    reset       = 1'b0;

    // Reset held with all switches on, then released.
    repeat (3) step();
    check("rst_db", 32'(bus.sw_db), 32'h0);
    check("rst_chg", 32'(bus.sw_chg), 32'h0);
    check("rst_evt", 32'(bus.sw_evt), 32'h0);
    reset = 1'b1;
    measure(12, first, nchg, chg_at);
    check("t1_lat", 32'(first), 32'd6);
    check("t1_nchg", 32'(nchg), 32'd1);
    check("t1_chg_at", 32'(chg_at), 32'd6);
    check("t1_db", 32'(bus.sw_db), 32'hFFFF);

    // Single bit rising: captured by s1 at edge 1, visible from edge 1+1+N.
    settle(16'h0000);
    bus.sw_raw = 16'h0008;
    measure(14, first, nchg, chg_at);
    check("t2_lat", 32'(first), 32'd6);
    check("t2_nchg", 32'(nchg), 32'd1);
    check("t2_db", 32'(bus.sw_db), 32'h0008);

    // Three-cycle glitch is rejected.
    settle(16'h0000);
    bus.sw_raw = 16'h0001;
    measure(3, n0, c0, a0);
    bus.sw_raw = 16'h0000;
    measure(12, first, nchg, chg_at);
    check("t3_nchg", 32'(c0 + nchg), 32'd0);
    check("t3_db", 32'(bus.sw_db), 32'h0);

    // Eight bits flipping together give one strobe.
    bus.sw_raw = 16'hA5A5;
    measure(12, first, nchg, chg_at);
    check("t4_lat", 32'(first), 32'd6);
    check("t4_nchg", 32'(nchg), 32'd1);
    check("t4_db", 32'(bus.sw_db), 32'hA5A5);

    // Reset mid-debounce discards the partial count.
    settle(16'h0000);
    bus.sw_raw = 16'h0080;
    repeat (3) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    measure(12, first, nchg, chg_at);
    check("t5_lat", 32'(first), 32'd6);
    check("t5_db", 32'(bus.sw_db), 32'h0080);

    // Sticky event flags and same-edge flip/clear.
    settle(16'h0000);
    bus.evt_clr = 1'b1;
    step();
    bus.evt_clr = 1'b0;
    bus.sw_raw  = 16'h0004;
    measure(12, first, nchg, chg_at);
`ifdef SW_DEBOUNCE_EVENT_LATCH_EN
    check("t6_evt2", 32'(bus.sw_evt), 32'h0004);
`else
    check("t6_evt2", 32'(bus.sw_evt), 32'h0000);
`endif
    bus.sw_raw = 16'h0024;
    repeat (5) step();
    bus.evt_clr = 1'b1;
    step();
    bus.evt_clr = 1'b0;
    check("t6_db", 32'(bus.sw_db), 32'h0024);
`ifdef SW_DEBOUNCE_EVENT_LATCH_EN
    check("t6_evt5", 32'(bus.sw_evt), 32'h0020);
`else
    check("t6_evt5", 32'(bus.sw_evt), 32'h0000);
`endif

    // Randomized activity: bursts of toggles, short glitches, occasional reset/clear.
    for (int k = 0; k < 2500; k++) begin
      reset       = ($urandom_range(0, 60) != 0);
      bus.evt_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) begin
        bus.sw_raw = bus.sw_raw ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
      end
      step();
    end
    reset       = 1'b1;
    bus.evt_clr = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
